// File: rtl/i2c_reply_decoder_pkg.sv
// Shared reply codes, error codes, command constant and decoder state type
// for the I2C-over-AUX reply decoder.
package i2c_reply_decoder_pkg;

  localparam logic [1:0] REP_ACK   = 2'b00;
  localparam logic [1:0] REP_NACK  = 2'b01;
  localparam logic [1:0] REP_DEFER = 2'b10;
  localparam logic [1:0] REP_RSVD  = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_HDR  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [1:0] CMD_READ = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WCNT,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // First error of a reply is sticky; later errors never overwrite it.
  function automatic logic [1:0] first_err(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur == ERR_NONE) ? nxt : cur;
  endfunction

endpackage

// File: rtl/i2c_reply_decoder.sv
// Parses AUX sink replies to I2C-over-AUX requests: header status, read data
// forwarding, partial-write byte count, and malformed/length/timeout errors.
module i2c_reply_decoder
  import i2c_reply_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] de_mux_i2c_cmd,
  input  logic [7:0] de_mux_i2c_len,
  input  logic       de_mux_i2c_tr_vld,
  input  logic       i2c_fsm_rx_s,
  input  logic [7:0] phy_rx_byte,
  input  logic       phy_rx_vld,
  input  logic       phy_rx_done,
  output logic [7:0] i2c_reply_data,
  output logic       i2c_reply_data_vld,
  output logic [3:0] i2c_reply_status,
  output logic [7:0] i2c_reply_wr_cnt,
  output logic [1:0] i2c_reply_err,
  output logic       i2c_reply_done
);

  localparam int            TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  state_t        r_state;
  logic [1:0]    r_cmd;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic          r_rx_s_d;
  logic [7:0]    r_data;
  logic          r_data_vld;
  logic [3:0]    r_status;
  logic [7:0]    r_wr_cnt;
  logic [1:0]    r_err;
  logic          r_done;

  logic   w_rise;
  logic   w_fall;
  logic   w_active;
  logic   w_hdr_bad;
  logic   w_timeout;
  logic [1:0] w_native;
  logic [1:0] w_i2c;
  state_t w_hdr_next;
  state_t w_after_byte;

  assign w_rise    = i2c_fsm_rx_s & ~r_rx_s_d;
  assign w_fall    = ~i2c_fsm_rx_s & r_rx_s_d;
  assign w_active  = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_WCNT);
  assign w_native  = phy_rx_byte[5:4];
  assign w_i2c     = phy_rx_byte[7:6];
  assign w_hdr_bad = (phy_rx_byte[3:0] != 4'h0) || (w_native == REP_RSVD) || (w_i2c == REP_RSVD);
  assign w_timeout = w_active && !phy_rx_vld && (r_timer == TMO);

  // Header routing and the state a received byte leaves us in; a coincident
  // done is judged against this post-byte state.
  always_comb begin
    w_hdr_next = ST_FLUSH;
    if (!w_hdr_bad && w_native == REP_ACK) begin
      if (w_i2c == REP_ACK && r_cmd == CMD_READ)       w_hdr_next = ST_DATA;
      else if (w_i2c == REP_NACK && r_cmd != CMD_READ) w_hdr_next = ST_WCNT;
    end

    w_after_byte = r_state;
    if (phy_rx_vld) begin
      case (r_state)
        ST_HDR:  w_after_byte = w_hdr_next;
        ST_DATA: w_after_byte = (r_cnt == r_len) ? ST_FLUSH : ST_DATA;
        ST_WCNT: w_after_byte = ST_FLUSH;
        default: w_after_byte = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 2'b00;
      r_len      <= 8'h00;
      r_cnt      <= 8'h00;
      r_timer    <= '0;
      r_rx_s_d   <= 1'b0;
      r_data     <= 8'h00;
      r_data_vld <= 1'b0;
      r_status   <= 4'h0;
      r_wr_cnt   <= 8'h00;
      r_err      <= ERR_NONE;
      r_done     <= 1'b0;
    end else begin
      r_rx_s_d   <= i2c_fsm_rx_s;
      r_data_vld <= 1'b0;
      r_done     <= 1'b0;

      if (phy_rx_vld || (r_state == ST_IDLE && w_rise)) r_timer <= '0;
      else if (r_timer != TMO)                          r_timer <= r_timer + 1'b1;

      if (w_fall && r_state != ST_IDLE && r_state != ST_DONE) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (de_mux_i2c_tr_vld) begin
              r_cmd <= de_mux_i2c_cmd;
              r_len <= de_mux_i2c_len;
            end
            if (w_rise) begin
              r_status <= 4'h0;
              r_err    <= ERR_NONE;
              r_wr_cnt <= 8'h00;
              r_cnt    <= 8'h00;
              r_state  <= ST_HDR;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: begin
            if (phy_rx_vld) begin
              case (r_state)
                ST_HDR: begin
                  r_status <= {w_i2c, w_native};
                  if (w_hdr_bad) r_err <= first_err(r_err, ERR_HDR);
                end
                ST_DATA: begin
                  r_data     <= phy_rx_byte;
                  r_data_vld <= 1'b1;
                  r_cnt      <= r_cnt + 8'd1;
                end
                ST_WCNT: r_wr_cnt <= phy_rx_byte;
                default: r_err <= first_err(r_err, ERR_LEN);
              endcase
            end

            if (phy_rx_done) begin
              if (w_after_byte == ST_HDR || w_after_byte == ST_DATA)
                r_err <= first_err(r_err, ERR_LEN);
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_timeout) begin
              r_err   <= first_err(r_err, ERR_TMO);
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= w_after_byte;
            end
          end
        endcase
      end
    end
  end

  assign i2c_reply_data     = r_data;
  assign i2c_reply_data_vld = r_data_vld;
  assign i2c_reply_status   = r_status;
  assign i2c_reply_wr_cnt   = r_wr_cnt;
  assign i2c_reply_err      = r_err;
  assign i2c_reply_done     = r_done;

endmodule

// File: tb/tb_i2c_reply_decoder.sv
// Directed bench for i2c_reply_decoder with data and completion scoreboards.
module tb_i2c_reply_decoder;

  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic [7:0] len;
  logic       tr_vld;
  logic       rx_s;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_done;
  logic [7:0] data;
  logic       data_vld;
  logic [3:0] status;
  logic [7:0] wr_cnt;
  logic [1:0] err;
  logic       done;

  i2c_reply_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .de_mux_i2c_cmd(cmd), .de_mux_i2c_len(len), .de_mux_i2c_tr_vld(tr_vld),
    .i2c_fsm_rx_s(rx_s),
    .phy_rx_byte(rx_byte), .phy_rx_vld(rx_vld), .phy_rx_done(rx_done),
    .i2c_reply_data(data), .i2c_reply_data_vld(data_vld),
    .i2c_reply_status(status), .i2c_reply_wr_cnt(wr_cnt),
    .i2c_reply_err(err), .i2c_reply_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [1:0] er;
    logic [7:0] wc;
  } done_t;

  logic [7:0] data_q[$];
  done_t      done_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_b;
  done_t      exp_d;
  always @(negedge clk) begin
    if (!rst) begin
      if (data_vld) begin
        if (data_q.size() == 0) chk("data_unexpected", 1, 0);
        else begin
          exp_b = data_q.pop_front();
          chk("data", data, exp_b);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          exp_d = done_q.pop_front();
          chk("status", status, exp_d.st);
          chk("err", err, exp_d.er);
          chk("wr_cnt", wr_cnt, exp_d.wc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input logic [1:0] c, input logic [7:0] l);
    cmd = c; len = l; tr_vld = 1'b1;
    tick();
    tr_vld = 1'b0;
    rx_s = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] b, input bit fwd, input bit with_done);
    rx_byte = b; rx_vld = 1'b1; rx_done = with_done;
    if (fwd) data_q.push_back(b);
    tick();
    rx_vld = 1'b0; rx_done = 1'b0;
  endtask

  task automatic expect_done(input logic [3:0] st, input logic [1:0] er, input logic [7:0] wc);
    done_t d;
    d.st = st; d.er = er; d.wc = wc;
    done_q.push_back(d);
  endtask

  task automatic close_win(input string tag);
    for (int k = 0; k < 10 && (done_q.size() != 0 || data_q.size() != 0); k++) tick();
    chk({tag, "_done_seen"}, done_q.size(), 0);
    chk({tag, "_data_left"}, data_q.size(), 0);
    done_q.delete();
    data_q.delete();
    rx_s = 1'b0;
    tick();
    tick();
  endtask

  int n;

  initial begin
    rst = 1'b1; cmd = 2'b00; len = 8'h00; tr_vld = 1'b0; rx_s = 1'b0;
    rx_byte = 8'h00; rx_vld = 1'b0; rx_done = 1'b0;
    repeat (3) tick();
    chk("rst_data", data, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_status", status, 0);
    chk("rst_wrcnt", wr_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Read ACK, four data bytes
    open_win(2'b01, 8'h03);
    send(8'h00, 0, 0);
    send(8'hA1, 1, 0); send(8'hA2, 1, 0); send(8'hA3, 1, 0); send(8'hA4, 1, 0);
    expect_done(4'h0, 2'b00, 8'h00);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("read4");

    // Write, I2C NACK with byte count
    open_win(2'b00, 8'h05);
    send(8'h40, 0, 0);
    send(8'h02, 0, 0);
    expect_done(4'b0100, 2'b00, 8'h02);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("wr_nack");

    // Native DEFER, then malformed DEFER header
    open_win(2'b01, 8'h03);
    expect_done(4'b0010, 2'b00, 8'h00);
    send(8'h20, 0, 1);
    close_win("defer");
    open_win(2'b01, 8'h03);
    expect_done(4'b0010, 2'b01, 8'h00);
    send(8'h21, 0, 0);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("defer_bad");

    // I2C DEFER on a read: no data phase, trailing byte is a length error
    open_win(2'b01, 8'h00);
    send(8'h80, 0, 0);
    send(8'h55, 0, 0);
    expect_done(4'b1000, 2'b10, 8'h00);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("i2c_defer");

    // Short read
    open_win(2'b01, 8'h03);
    send(8'h00, 0, 0);
    send(8'h11, 1, 0); send(8'h22, 1, 0);
    expect_done(4'h0, 2'b10, 8'h00);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("short");

    // Long read: len=0, second byte dropped
    open_win(2'b01, 8'h00);
    send(8'h00, 0, 0);
    send(8'hB1, 1, 0); send(8'hB2, 0, 0);
    expect_done(4'h0, 2'b10, 8'h00);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("long");

    // Timeout with no bytes
    cmd = 2'b01; len = 8'h01; tr_vld = 1'b1; tick(); tr_vld = 1'b0;
    expect_done(4'h0, 2'b11, 8'h00);
    rx_s = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < TMO + 50);
    chk("tmo_latency", n - 1, TMO + 1);
    close_win("tmo");

    // Last data byte coincides with done
    open_win(2'b01, 8'h01);
    send(8'h00, 0, 0);
    send(8'hC1, 1, 0);
    expect_done(4'h0, 2'b00, 8'h00);
    send(8'hC2, 1, 1);
    close_win("last_done");

    // Async reset mid-read
    open_win(2'b01, 8'h03);
    send(8'h00, 0, 0);
    send(8'hD1, 1, 0); send(8'hD2, 1, 0);
    tick();
    #2 rst = 1'b1; rx_s = 1'b0;
    #1;
    chk("arst_data", data, 0);
    chk("arst_vld", data_vld, 0);
    chk("arst_done", done, 0);
    data_q.delete();
    done_q.delete();
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("arst_no_done", done, 0);

    // Clean read after reset
    open_win(2'b01, 8'h01);
    send(8'h00, 0, 0);
    send(8'hE1, 1, 0); send(8'hE2, 1, 0);
    expect_done(4'h0, 2'b00, 8'h00);
    rx_done = 1'b1; tick(); rx_done = 1'b0;
    close_win("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
